vx_warp_barrier_ctrl: RTL and testbench

//  Per-core warp barrier scheduler. Accepts barrier arrivals (gpu_barrier_t fields) from
//  the issue stage, holds arriving warps stalled, and releases all participants in one cycle

---
 rtl/vx_warp_barrier_ctrl_pkg.sv | 35 +++
 rtl/vx_warp_barrier_ctrl_if.sv | 27 ++
 rtl/vx_warp_barrier_ctrl_slot.sv | 58 +++++
 rtl/vx_warp_barrier_ctrl.sv | 76 +++++++
 tb/tb_vx_warp_barrier_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/vx_warp_barrier_ctrl_pkg.sv
// rtl/vx_warp_barrier_ctrl_pkg.sv - shared widths, barrier request/release types and helpers
package vx_warp_barrier_ctrl_pkg;

  localparam int NUM_WARPS    = 4;
  localparam int NUM_BARRIERS = 4;
  localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  typedef struct packed {
    logic               valid;
    logic [NB_BITS-1:0] id;
    logic [NW_BITS-1:0] size_m1;
  } gpu_barrier_t;

  typedef struct packed {
    logic                 valid;
    logic [NUM_WARPS-1:0] wmask;
  } gpu_barrier_rel_t;

  function automatic logic [NUM_WARPS-1:0] wid_onehot(input logic [NW_BITS-1:0] wid);
    logic [NUM_WARPS-1:0] m;
    m      = '0;
    m[wid] = 1'b1;
    return m;
  endfunction

  // NW_BITS+1 bits always hold NUM_WARPS
  function automatic logic [NW_BITS:0] popcount(input logic [NUM_WARPS-1:0] m);
    logic [NW_BITS:0] c;
    c = '0;
    for (int i = 0; i < NUM_WARPS; i++) c = c + {{NW_BITS{1'b0}}, m[i]};
    return c;
  endfunction

endpackage

// File: rtl/vx_warp_barrier_ctrl_if.sv
// rtl/vx_warp_barrier_ctrl_if.sv - arrival, flush, stall and release signals of the barrier block
interface vx_warp_barrier_ctrl_if;
  import vx_warp_barrier_ctrl_pkg::*;

  logic                 req_valid;
  logic [NW_BITS-1:0]   req_wid;
  logic [NB_BITS-1:0]   req_id;
  logic [NW_BITS-1:0]   req_size_m1;
  logic                 req_ready;
  logic                 flush_valid;
  logic [NW_BITS-1:0]   flush_wid;
  logic [NUM_WARPS-1:0] stall_mask;
  logic                 release_valid;
  logic [NUM_WARPS-1:0] release_mask;
  logic [31:0]          perf_stalls;

  modport master (
    output req_valid, req_wid, req_id, req_size_m1, flush_valid, flush_wid,
    input  req_ready, stall_mask, release_valid, release_mask, perf_stalls
  );

  modport slave (
    input  req_valid, req_wid, req_id, req_size_m1, flush_valid, flush_wid,
    output req_ready, stall_mask, release_valid, release_mask, perf_stalls
  );

endinterface

// File: rtl/vx_warp_barrier_ctrl_slot.sv
// rtl/vx_warp_barrier_ctrl_slot.sv - one barrier slot: arrival count, parked warp mask, latched size
module vx_barrier_slot
  import vx_warp_barrier_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 arrive_valid,
  input  logic [NW_BITS-1:0]   arrive_wid,
  input  logic [NW_BITS-1:0]   arrive_size_m1,
  input  logic                 flush_valid,
  input  logic [NW_BITS-1:0]   flush_wid,
  output logic                 complete,
  output logic [NUM_WARPS-1:0] rel_mask,
  output logic [NUM_WARPS-1:0] wmask
);

  logic [NW_BITS:0]     cnt_q, cnt_f;
  logic [NUM_WARPS-1:0] wmask_q, wmask_f, arrive_bit;
  logic [NW_BITS-1:0]   size_q, size_eff;
  logic                 flush_hit;

  // Flush is folded in first so a same-cycle arrival sees the post-flush slot
  always_comb begin
    flush_hit  = flush_valid && wmask_q[flush_wid];
    wmask_f    = flush_hit ? (wmask_q & ~wid_onehot(flush_wid)) : wmask_q;
    cnt_f      = cnt_q - {{NW_BITS{1'b0}}, flush_hit};
    size_eff   = (cnt_f == '0) ? arrive_size_m1 : size_q;
    arrive_bit = wid_onehot(arrive_wid);
    complete   = arrive_valid && (cnt_f == {1'b0, size_eff});
    rel_mask   = complete ? (wmask_f | arrive_bit) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      wmask_q <= '0;
      size_q  <= '0;
    end else if (complete) begin
      cnt_q   <= '0;
      wmask_q <= '0;
    end else if (arrive_valid) begin
      cnt_q   <= cnt_f + {{NW_BITS{1'b0}}, 1'b1};
      wmask_q <= wmask_f | arrive_bit;
      if (cnt_f == '0) size_q <= arrive_size_m1;
    end else begin
      cnt_q   <= cnt_f;
      wmask_q <= wmask_f;
    end
  end

  assign wmask = wmask_q;

  a_size_consistent: assert property (@(posedge clk) disable iff (!reset_n)
    (arrive_valid && cnt_f != '0) |-> (arrive_size_m1 == size_q));
  a_size_range: assert property (@(posedge clk) disable iff (!reset_n)
    arrive_valid |-> (32'(arrive_size_m1) < NUM_WARPS));

endmodule

// File: rtl/vx_warp_barrier_ctrl.sv
// rtl/vx_warp_barrier_ctrl.sv - per-core warp barrier scheduler: parks arriving warps, releases on completion
// Optional stall counter built when BARRIER_PERF_EN is defined.
module vx_warp_barrier_ctrl
  import vx_warp_barrier_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  vx_warp_barrier_ctrl_if.slave bus
);

  logic                 ready_q;
  gpu_barrier_t         req;
  gpu_barrier_rel_t     rel_q;
  logic [NUM_BARRIERS-1:0] slot_complete;
  logic [NUM_WARPS-1:0] slot_rel   [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] slot_wmask [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] rel_mask_any, stall_any;

  assign req = '{valid: bus.req_valid & ready_q, id: bus.req_id, size_m1: bus.req_size_m1};

  for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
    vx_barrier_slot u_slot (
      .clk            (clk),
      .reset_n        (reset_n),
      .arrive_valid   (req.valid && (req.id == NB_BITS'(b))),
      .arrive_wid     (bus.req_wid),
      .arrive_size_m1 (req.size_m1),
      .flush_valid    (bus.flush_valid),
      .flush_wid      (bus.flush_wid),
      .complete       (slot_complete[b]),
      .rel_mask       (slot_rel[b]),
      .wmask          (slot_wmask[b])
    );
  end

  always_comb begin
    rel_mask_any = '0;
    stall_any    = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      rel_mask_any = rel_mask_any | slot_rel[b];
      stall_any    = stall_any | slot_wmask[b];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      rel_q   <= '0;
    end else begin
      ready_q     <= 1'b1;
      rel_q.valid <= |slot_complete;
      rel_q.wmask <= rel_mask_any;
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.stall_mask    = stall_any;
  assign bus.release_valid = rel_q.valid;
  assign bus.release_mask  = rel_q.wmask;

`ifdef BARRIER_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_q <= '0;
    else          perf_q <= perf_q + 32'(popcount(stall_any));
  end
  assign bus.perf_stalls = perf_q;
`else
  assign bus.perf_stalls = '0;
`endif

  // A warp re-arriving while parked is only legal when it is being flushed the same cycle
  a_no_double_park: assert property (@(posedge clk) disable iff (!reset_n)
    req.valid |-> (!stall_any[bus.req_wid] || (bus.flush_valid && bus.flush_wid == bus.req_wid)));

endmodule

// File: tb/tb_vx_warp_barrier_ctrl.sv
// tb/tb_vx_warp_barrier_ctrl.sv - directed vector bench for the warp barrier scheduler
module tb_vx_warp_barrier_ctrl;
  import vx_warp_barrier_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vx_warp_barrier_ctrl_if bif ();

  vx_warp_barrier_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  typedef struct {
    logic       rv;
    logic [1:0] wid;
    logic [1:0] id;
    logic [1:0] sz;
    logic       fv;
    logic [1:0] fw;
    logic [3:0] st;
    logic       rlv;
    logic [3:0] rlm;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_perf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rv, input logic [1:0] wid, input logic [1:0] id, input logic [1:0] sz,
                     input logic fv, input logic [1:0] fw,
                     input logic [3:0] st, input logic rlv, input logic [3:0] rlm);
    vec_t v;
    v = '{rv: rv, wid: wid, id: id, sz: sz, fv: fv, fw: fw, st: st, rlv: rlv, rlm: rlm};
    vq.push_back(v);
  endtask

  task automatic drive(input logic rv, input logic [1:0] wid, input logic [1:0] id, input logic [1:0] sz,
                       input logic fv, input logic [1:0] fw);
    bif.req_valid   = rv;
    bif.req_wid     = wid;
    bif.req_id      = id;
    bif.req_size_m1 = sz;
    bif.flush_valid = fv;
    bif.flush_wid   = fw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  rv wid id sz  fv fw   stall     rlv rlm
    add(1, 0, 1, 3,  0, 0,  4'b0001, 0, 4'b0000);
    add(1, 1, 1, 3,  0, 0,  4'b0011, 0, 4'b0000);
    add(1, 2, 1, 3,  0, 0,  4'b0111, 0, 4'b0000);
    add(1, 3, 1, 3,  0, 0,  4'b0000, 1, 4'b1111);
    add(0, 0, 0, 0,  0, 0,  4'b0000, 0, 4'b0000);
    add(1, 2, 0, 0,  0, 0,  4'b0000, 1, 4'b0100);
    add(0, 0, 0, 0,  0, 0,  4'b0000, 0, 4'b0000);
    add(1, 0, 0, 1,  0, 0,  4'b0001, 0, 4'b0000);
    add(1, 1, 2, 2,  0, 0,  4'b0011, 0, 4'b0000);
    add(1, 2, 2, 2,  0, 0,  4'b0111, 0, 4'b0000);
    add(1, 3, 0, 1,  0, 0,  4'b0110, 1, 4'b1001);
    add(1, 0, 2, 2,  0, 0,  4'b0000, 1, 4'b0111);
    add(0, 0, 0, 0,  0, 0,  4'b0000, 0, 4'b0000);
    add(1, 0, 3, 2,  0, 0,  4'b0001, 0, 4'b0000);
    add(1, 1, 3, 2,  0, 0,  4'b0011, 0, 4'b0000);
    add(0, 0, 0, 0,  1, 1,  4'b0001, 0, 4'b0000);
    add(1, 1, 3, 2,  0, 0,  4'b0011, 0, 4'b0000);
    add(1, 2, 3, 2,  0, 0,  4'b0000, 1, 4'b0111);
    add(0, 0, 0, 0,  0, 0,  4'b0000, 0, 4'b0000);
    add(1, 0, 1, 1,  0, 0,  4'b0001, 0, 4'b0000);
    add(1, 0, 1, 1,  1, 0,  4'b0001, 0, 4'b0000);
    add(1, 1, 1, 1,  0, 0,  4'b0000, 1, 4'b0011);
    add(0, 0, 0, 0,  1, 3,  4'b0000, 0, 4'b0000);
    add(1, 0, 0, 2,  0, 0,  4'b0001, 0, 4'b0000);
    add(1, 1, 0, 2,  0, 0,  4'b0011, 0, 4'b0000);
    add(1, 2, 0, 2,  1, 0,  4'b0110, 0, 4'b0000);
    add(1, 3, 0, 2,  0, 0,  4'b0000, 1, 4'b1110);
    add(0, 0, 0, 0,  0, 0,  4'b0000, 0, 4'b0000);

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("reset_ready", 32'(bif.req_ready), 0);
    chk("reset_stall", 32'(bif.stall_mask), 0);
    chk("reset_rel_valid", 32'(bif.release_valid), 0);
    chk("reset_rel_mask", 32'(bif.release_mask), 0);
    chk("reset_perf", bif.perf_stalls, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'(bif.req_ready), 1);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rv, vq[i].wid, vq[i].id, vq[i].sz, vq[i].fv, vq[i].fw);
      tick();
      chk($sformatf("vec%0d_stall", i), 32'(bif.stall_mask), 32'(vq[i].st));
      chk($sformatf("vec%0d_rel_valid", i), 32'(bif.release_valid), 32'(vq[i].rlv));
      chk($sformatf("vec%0d_rel_mask", i), 32'(bif.release_mask), 32'(vq[i].rlm));
    end
    drive(0, 0, 0, 0, 0, 0);

    // Reset with three parked warps: everything drops without a clock edge
    for (int w = 0; w < 3; w++) begin
      drive(1, 2'(w), 1, 3, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("parked_before_reset", 32'(bif.stall_mask), 32'h7);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_stall", 32'(bif.stall_mask), 0);
    chk("async_rel_valid", 32'(bif.release_valid), 0);
    chk("async_rel_mask", 32'(bif.release_mask), 0);
    chk("async_ready", 32'(bif.req_ready), 0);
    chk("async_perf", bif.perf_stalls, 0);
    repeat (2) begin
      tick();
      chk("no_release_in_reset", 32'(bif.release_valid), 0);
    end
    reset_n = 1'b1;
    tick();
    chk("post_reset_ready", 32'(bif.req_ready), 1);
    chk("post_reset_stall", 32'(bif.stall_mask), 0);
    chk("post_reset_rel", 32'(bif.release_valid), 0);

    // Two warps parked for ten cycles
    drive(1, 0, 2, 3, 0, 0);
    tick();
    drive(1, 1, 2, 3, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
`ifdef BARRIER_PERF_EN
    exp_perf = 32'd1;
`else
    exp_perf = 32'd0;
`endif
    chk("perf_after_park", bif.perf_stalls, exp_perf);
    repeat (10) tick();
`ifdef BARRIER_PERF_EN
    exp_perf = 32'd21;
`else
    exp_perf = 32'd0;
`endif
    chk("perf_after_10", bif.perf_stalls, exp_perf);
    chk("perf_stall_mask", 32'(bif.stall_mask), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
